// File: rtl/morse_symbol_sequencer_pkg.sv
// Shared types and defaults for the Morse symbol sequencer: frame layout,
// sequencer states and the release-gap thresholds at a 100 kHz tick.
package morse_pkg;

  localparam int unsigned GAP_CNT_W       = 18;
  localparam int unsigned FRAME_SYMS      = 6;
  localparam int unsigned DEF_CHAR_GAP_TH = 60000;
  localparam int unsigned DEF_WORD_GAP_TH = 140000;

  typedef struct packed {
    logic [5:0] bits;
    logic [2:0] len;
    logic       err;
    logic       space;
  } morse_frame_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COLLECT   = 2'd1,
    WAIT_WORD = 2'd2
  } morse_state_t;

  // A word break carries no symbols, only the space marker.
  function automatic morse_frame_t spaceFrame();
    morse_frame_t f;
    f       = '0;
    f.space = 1'b1;
    return f;
  endfunction

endpackage

// File: rtl/morse_symbol_sequencer_if.sv
// Valid/ready stream of completed Morse frames toward the character decoder.
interface morse_symbol_sequencer_if;

  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_bits;
  logic [2:0] out_len;
  logic       out_space;
  logic       out_err;

  modport master (
    output out_valid,
    output out_bits,
    output out_len,
    output out_space,
    output out_err,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_bits,
    input  out_len,
    input  out_space,
    input  out_err,
    output out_ready
  );

endinterface

// File: rtl/morse_symbol_sequencer_fifo.sv
// Two-entry first-word-fall-through frame queue; entry0 is always the head,
// so the head outputs come straight from a register.
module morse_frame_fifo
  import morse_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  morse_frame_t pushData_i,
  input  logic         pop_i,
  output morse_frame_t head_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [1:0]   count_q;
  morse_frame_t entry0_q;
  morse_frame_t entry1_q;
  logic         popEn;

  always_comb begin
    popEn = pop_i && (count_q != 2'd0);
  end

  // A push into a full queue without a simultaneous pop is silently ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= 2'd0;
      entry0_q <= '0;
      entry1_q <= '0;
    end else begin
      case ({push_i, popEn})
        2'b11: begin
          if (count_q == 2'd1) begin
            entry0_q <= pushData_i;
          end else begin
            entry0_q <= entry1_q;
            entry1_q <= pushData_i;
          end
        end
        2'b01: begin
          if (count_q == 2'd2) begin
            entry0_q <= entry1_q;
          end else begin
            entry0_q <= '0;
          end
          entry1_q <= '0;
          count_q  <= count_q - 2'd1;
        end
        2'b10: begin
          if (count_q == 2'd0) begin
            entry0_q <= pushData_i;
            count_q  <= 2'd1;
          end else if (count_q == 2'd1) begin
            entry1_q <= pushData_i;
            count_q  <= 2'd2;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign head_o  = entry0_q;
  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);

endmodule

// File: rtl/morse_symbol_sequencer.sv
// Assembles classified dot/dash pulses into character frames, times release
// gaps to close characters and emit word breaks, and queues the frames.
module morse_symbol_sequencer
  import morse_pkg::*;
#(
  parameter int unsigned CHAR_GAP_TH = DEF_CHAR_GAP_TH,
  parameter int unsigned WORD_GAP_TH = DEF_WORD_GAP_TH,
  parameter int unsigned MAX_SYMS    = FRAME_SYMS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      btn_in,
  input  logic                      sym_valid,
  input  logic                      sym_is_long,
  morse_symbol_sequencer_if.master  out_if,
  output logic                      ovf,
  input  logic                      ovf_clr
);

  localparam logic [GAP_CNT_W-1:0] CHAR_TH = GAP_CNT_W'(CHAR_GAP_TH);
  localparam logic [GAP_CNT_W-1:0] WORD_TH = GAP_CNT_W'(WORD_GAP_TH);
  localparam logic [GAP_CNT_W-1:0] GAP_MAX = '1;
  localparam logic [2:0]           MAX_LEN = 3'(MAX_SYMS);

  morse_state_t         state_q;
  logic [GAP_CNT_W-1:0] gapCnt_q;
  logic [GAP_CNT_W-1:0] gapCnt_d;
  logic [5:0]           bits_q;
  logic [2:0]           len_q;
  logic                 err_q;
  logic                 ovf_q;

  logic                 charClose;
  logic                 wordClose;
  logic                 pushValid;
  morse_frame_t         pushFrame;
  morse_frame_t         headFrame;
  logic                 fifoFull;
  logic                 fifoEmpty;
  logic                 dropFrame;

  always_comb begin
    gapCnt_d = gapCnt_q;
    if (sym_valid || btn_in) begin
      gapCnt_d = '0;
    end else if (gapCnt_q != GAP_MAX) begin
      gapCnt_d = gapCnt_q + 1'b1;
    end
  end

  // A symbol arriving on the threshold cycle keeps the character open.
  always_comb begin
    charClose = (state_q == COLLECT)   && !sym_valid && (gapCnt_q == CHAR_TH);
    wordClose = (state_q == WAIT_WORD) && !sym_valid && (gapCnt_q == WORD_TH);
    pushValid = charClose || wordClose;
    pushFrame = '0;
    if (charClose) begin
      pushFrame.bits = bits_q;
      pushFrame.len  = len_q;
      pushFrame.err  = err_q;
    end else if (wordClose) begin
      pushFrame = spaceFrame();
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gapCnt_q <= '0;
      bits_q   <= '0;
      len_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      gapCnt_q <= gapCnt_d;
      case (state_q)
        IDLE, WAIT_WORD: begin
          if (sym_valid) begin
            bits_q  <= {5'b0, sym_is_long};
            len_q   <= 3'd1;
            err_q   <= 1'b0;
            state_q <= COLLECT;
          end else if (wordClose) begin
            state_q <= IDLE;
          end
        end
        COLLECT: begin
          if (sym_valid) begin
            if (len_q < MAX_LEN) begin
              bits_q[len_q] <= sym_is_long;
              len_q         <= len_q + 3'd1;
            end else begin
              err_q <= 1'b1;
            end
          end else if (charClose) begin
            bits_q  <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
            state_q <= WAIT_WORD;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // A full queue pops exactly when downstream is ready, so that is the only escape.
  assign dropFrame = pushValid && fifoFull && !out_if.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (dropFrame) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  morse_frame_fifo u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (pushValid),
    .pushData_i (pushFrame),
    .pop_i      (out_if.out_ready),
    .head_o     (headFrame),
    .full_o     (fifoFull),
    .empty_o    (fifoEmpty)
  );

  assign out_if.out_valid = !fifoEmpty;
  assign out_if.out_bits  = headFrame.bits;
  assign out_if.out_len   = headFrame.len;
  assign out_if.out_space = headFrame.space;
  assign out_if.out_err   = headFrame.err;
  assign ovf              = ovf_q;

endmodule

// File: tb/tb_morse_symbol_sequencer.sv
// Directed scenarios for morse_symbol_sequencer with short gap thresholds
// (character close at 20 ticks, word break at 50 ticks).
module tb_morse_symbol_sequencer;
  import morse_pkg::*;

  logic clk;
  logic rst_n;
  logic btn_in;
  logic sym_valid;
  logic sym_is_long;
  logic ovf;
  logic ovf_clr;
  int   checks;
  int   errors;

  morse_symbol_sequencer_if bus ();

  morse_symbol_sequencer #(
    .CHAR_GAP_TH (20),
    .WORD_GAP_TH (50),
    .MAX_SYMS    (6)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_in      (btn_in),
    .sym_valid   (sym_valid),
    .sym_is_long (sym_is_long),
    .out_if      (bus),
    .ovf         (ovf),
    .ovf_clr     (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    sym_valid   = 1'b0;
    sym_is_long = 1'b0;
    btn_in      = 1'b0;
    ovf_clr     = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One-cycle symbol pulse; returns on the falling edge after it was sampled.
  task automatic send_sym(input logic isLong);
    @(negedge clk);
    sym_valid   = 1'b1;
    sym_is_long = isLong;
    @(negedge clk);
    sym_valid   = 1'b0;
    sym_is_long = 1'b0;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    btn_in        = 1'b0;
    sym_valid     = 1'b0;
    sym_is_long   = 1'b0;
    ovf_clr       = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b expected 0", bus.out_valid); end
    checks++; if (bus.out_bits !== 6'd0) begin errors++; $display("[TB] FAIL reset_bits: got %b expected 000000", bus.out_bits); end
    checks++; if (bus.out_len !== 3'd0) begin errors++; $display("[TB] FAIL reset_len: got %0d expected 0", bus.out_len); end
    checks++; if (bus.out_space !== 1'b0 || bus.out_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags: got space=%0b err=%0b expected 0/0", bus.out_space, bus.out_err); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf: got %0b expected 0", ovf); end
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("[TB] FAIL reset_state: got %0d expected %0d", dut.state_q, IDLE); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_char_frame();
    int riseAt;
    int nFrames;
    morse_frame_t got;
    $display("[TB] dot-dash character");
    do_reset();
    bus.out_ready = 1'b1;
    send_sym(1'b0);
    send_sym(1'b1);
    riseAt  = 0;
    nFrames = 0;
    got     = '0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        nFrames++;
        if (riseAt == 0) begin
          riseAt    = i;
          got.bits  = bus.out_bits;
          got.len   = bus.out_len;
          got.err   = bus.out_err;
          got.space = bus.out_space;
        end
      end
    end
    checks++; if (riseAt != 21) begin errors++; $display("[TB] FAIL char_latency: got %0d expected 21", riseAt); end
    checks++; if (nFrames != 1) begin errors++; $display("[TB] FAIL char_count: got %0d expected 1", nFrames); end
    checks++; if (got.bits !== 6'b000010) begin errors++; $display("[TB] FAIL char_bits: got %b expected 000010", got.bits); end
    checks++; if (got.len !== 3'd2) begin errors++; $display("[TB] FAIL char_len: got %0d expected 2", got.len); end
    checks++; if (got.err !== 1'b0 || got.space !== 1'b0) begin errors++; $display("[TB] FAIL char_flags: got err=%0b space=%0b expected 0/0", got.err, got.space); end
  endtask

  task automatic test_word_space();
    int tAt[2];
    morse_frame_t fr[2];
    int nFrames;
    $display("[TB] dot then word gap");
    do_reset();
    bus.out_ready = 1'b1;
    send_sym(1'b0);
    nFrames = 0;
    tAt[0] = 0; tAt[1] = 0;
    fr[0] = '0; fr[1] = '0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        if (nFrames < 2) begin
          tAt[nFrames]       = i;
          fr[nFrames].bits   = bus.out_bits;
          fr[nFrames].len    = bus.out_len;
          fr[nFrames].err    = bus.out_err;
          fr[nFrames].space  = bus.out_space;
        end
        nFrames++;
      end
    end
    checks++; if (nFrames != 2) begin errors++; $display("[TB] FAIL word_count: got %0d expected 2", nFrames); end
    checks++; if (tAt[0] != 21) begin errors++; $display("[TB] FAIL word_letter_time: got %0d expected 21", tAt[0]); end
    checks++; if (fr[0].len !== 3'd1 || fr[0].bits !== 6'd0 || fr[0].space !== 1'b0) begin errors++; $display("[TB] FAIL word_letter: got len=%0d bits=%b space=%0b expected 1/000000/0", fr[0].len, fr[0].bits, fr[0].space); end
    checks++; if (tAt[1] != 51) begin errors++; $display("[TB] FAIL word_space_time: got %0d expected 51", tAt[1]); end
    checks++; if (fr[1].space !== 1'b1 || fr[1].len !== 3'd0 || fr[1].bits !== 6'd0) begin errors++; $display("[TB] FAIL word_space: got space=%0b len=%0d bits=%b expected 1/0/000000", fr[1].space, fr[1].len, fr[1].bits); end
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("[TB] FAIL word_state: got %0d expected %0d", dut.state_q, IDLE); end
  endtask

  task automatic test_overlong();
    int riseAt;
    morse_frame_t got;
    $display("[TB] seven dashes");
    do_reset();
    bus.out_ready = 1'b1;
    @(negedge clk);
    sym_valid   = 1'b1;
    sym_is_long = 1'b1;
    repeat (7) @(negedge clk);
    sym_valid   = 1'b0;
    sym_is_long = 1'b0;
    riseAt = 0;
    got    = '0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1 && riseAt == 0) begin
        riseAt    = i;
        got.bits  = bus.out_bits;
        got.len   = bus.out_len;
        got.err   = bus.out_err;
        got.space = bus.out_space;
      end
    end
    checks++; if (riseAt != 21) begin errors++; $display("[TB] FAIL err_latency: got %0d expected 21", riseAt); end
    checks++; if (got.bits !== 6'b111111) begin errors++; $display("[TB] FAIL err_bits: got %b expected 111111", got.bits); end
    checks++; if (got.len !== 3'd6) begin errors++; $display("[TB] FAIL err_len: got %0d expected 6", got.len); end
    checks++; if (got.err !== 1'b1 || got.space !== 1'b0) begin errors++; $display("[TB] FAIL err_flags: got err=%0b space=%0b expected 1/0", got.err, got.space); end
  endtask

  task automatic test_btn_hold();
    int nValid;
    int nFrames;
    morse_frame_t got;
    $display("[TB] press held between symbols");
    do_reset();
    bus.out_ready = 1'b1;
    send_sym(1'b0);
    btn_in = 1'b1;
    nValid = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) nValid++;
    end
    btn_in = 1'b0;
    checks++; if (nValid != 0) begin errors++; $display("[TB] FAIL hold_no_close: got %0d frames expected 0", nValid); end
    checks++; if (dut.state_q !== COLLECT) begin errors++; $display("[TB] FAIL hold_state: got %0d expected %0d", dut.state_q, COLLECT); end
    send_sym(1'b1);
    nFrames = 0;
    got     = '0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        if (nFrames == 0) begin
          got.bits = bus.out_bits;
          got.len  = bus.out_len;
        end
        nFrames++;
      end
    end
    checks++; if (nFrames != 1) begin errors++; $display("[TB] FAIL hold_count: got %0d expected 1", nFrames); end
    checks++; if (got.len !== 3'd2 || got.bits !== 6'b000010) begin errors++; $display("[TB] FAIL hold_frame: got len=%0d bits=%b expected 2/000010", got.len, got.bits); end
  endtask

  task automatic test_back_to_back();
    $display("[TB] back-pressure and overflow");
    do_reset();
    bus.out_ready = 1'b0;
    send_sym(1'b0);
    repeat (25) @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_len !== 3'd1 || bus.out_bits !== 6'd0) begin errors++; $display("[TB] FAIL bp_first: got v=%0b len=%0d bits=%b expected 1/1/000000", bus.out_valid, bus.out_len, bus.out_bits); end
    send_sym(1'b1);
    repeat (25) @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_len !== 3'd1 || bus.out_bits !== 6'd0) begin errors++; $display("[TB] FAIL bp_stable: got v=%0b len=%0d bits=%b expected 1/1/000000", bus.out_valid, bus.out_len, bus.out_bits); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL bp_no_ovf: got %0b expected 0", ovf); end
    send_sym(1'b0);
    send_sym(1'b0);
    repeat (25) @(negedge clk);
    checks++; if (ovf !== 1'b1) begin errors++; $display("[TB] FAIL bp_ovf_set: got %0b expected 1", ovf); end
    checks++; if (bus.out_len !== 3'd1 || bus.out_bits !== 6'd0) begin errors++; $display("[TB] FAIL bp_head_kept: got len=%0d bits=%b expected 1/000000", bus.out_len, bus.out_bits); end
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL bp_ovf_clr: got %0b expected 0", ovf); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_len !== 3'd1 || bus.out_bits !== 6'b000001) begin errors++; $display("[TB] FAIL bp_second: got v=%0b len=%0d bits=%b expected 1/1/000001", bus.out_valid, bus.out_len, bus.out_bits); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_drained: got %0b expected 0", bus.out_valid); end
  endtask

  task automatic test_reset_mid_char();
    int nValid;
    $display("[TB] reset during collection");
    do_reset();
    bus.out_ready = 1'b0;
    send_sym(1'b1);
    repeat (25) @(negedge clk);
    send_sym(1'b0);
    send_sym(1'b1);
    send_sym(1'b1);
    checks++; if (dut.state_q !== COLLECT || dut.len_q !== 3'd3) begin errors++; $display("[TB] FAIL rst_pre_state: got state=%0d len=%0d expected %0d/3", dut.state_q, dut.len_q, COLLECT); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL rst_pre_valid: got %0b expected 1", bus.out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_async_valid: got %0b expected 0", bus.out_valid); end
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("[TB] FAIL rst_async_state: got %0d expected %0d", dut.state_q, IDLE); end
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    nValid = 0;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) nValid++;
    end
    checks++; if (nValid != 0) begin errors++; $display("[TB] FAIL rst_no_frame: got %0d frames expected 0", nValid); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_char_frame();
    test_word_space();
    test_overlong();
    test_btn_hold();
    test_back_to_back();
    test_reset_mid_char();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/morse_symbol_sequencer.md
# morse_symbol_sequencer

Sequences classified press events into Morse characters and word breaks for the decoder. Sits between `Signal_Classifier` (per-press `valid`/`is_long` pulses) and the character decoder. Assembles dot/dash symbols into a character frame, times the release gaps at 100 kHz to close characters and words, and queues completed frames in a 2-entry output FIFO with valid/ready back-pressure.

## Interface
Parameters:
- `CHAR_GAP_TH`, default 60000: release ticks after the last symbol that close a character (600 ms).
- `WORD_GAP_TH`, default 140000: release ticks after the last symbol that emit a word space (1.4 s). Must be greater than `CHAR_GAP_TH`.
- `MAX_SYMS`, default 6: symbols per character.

Ports:
- `clk` in 1: 100 kHz system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `btn_in` in 1: debounced button, high while pressed. Same signal that feeds the classifier.
- `sym_valid` in 1: one-cycle pulse, one symbol classified.
- `sym_is_long` in 1: 1 = dash, 0 = dot. Qualified by `sym_valid`.
- `out_valid` out 1: FIFO head valid.
- `out_ready` in 1: downstream accepts the head.
- `out_bits` out 6: symbols of the character. Bit 0 is the first symbol; 1 = dash. Bits at or above `out_len` are 0.
- `out_len` out 3: symbol count, 1..`MAX_SYMS`. 0 for a space.
- `out_space` out 1: entry is a word break.
- `out_err` out 1: character exceeded `MAX_SYMS`.
- `ovf` out 1: sticky flag, a frame was dropped because the FIFO was full.
- `ovf_clr` in 1: clears `ovf`.

## Operation
- States:
  - IDLE: no partial character; word gap already emitted or not yet armed.
  - COLLECT: 1 or more symbols buffered.
  - WAIT_WORD: character emitted; timing toward a word break.
- `gap_cnt` (18 bit, saturating):
  - Cleared on `sym_valid` or `btn_in`=1.
  - Otherwise increments.
  - `sym_valid` has priority over increment.
- IDLE:
  - `sym_valid` loads symbol 0, sets len=1 and goes to COLLECT.
  - Gap counting has no effect in IDLE.
- COLLECT:
  - `sym_valid` with len<`MAX_SYMS` writes bit[len] and increments len.
  - `sym_valid` with len=`MAX_SYMS` sets err and discards the symbol; len and bits are unchanged.
  - When `gap_cnt`==`CHAR_GAP_TH`, push {bits,len,err,space=0}, clear the assembly register and go to WAIT_WORD.
- WAIT_WORD:
  - `sym_valid` starts a new character (len=1) and goes to COLLECT; no space is emitted.
  - When `gap_cnt`==`WORD_GAP_TH`, push {0,0,0,space=1} and go to IDLE.
- A press with no `sym_valid` yet only holds `gap_cnt` at 0. The state does not change.
- FIFO:
  - 2 entries, first-word-fall-through.
  - Pop when `out_valid`&&`out_ready`.
  - Push and pop in the same cycle are both honoured, including when full.
  - A push while full and not popping drops the frame and sets `ovf`. The state machine advances regardless.
- `ovf_clr` clears `ovf`. If a drop happens in the same cycle, set wins.

## Timing
- Reset values:
  - State IDLE; `gap_cnt`, assembly register, FIFO and `ovf` all 0.
  - `out_valid`, `out_bits`, `out_len`, `out_space`, `out_err` = 0.
- Reset mid-character discards all partial and queued frames.
- Push occurs in the cycle `gap_cnt` equals the threshold. `out_valid` rises the next cycle if the FIFO was empty.
- Close-to-output latency is therefore `CHAR_GAP_TH`+1 cycles after the `sym_valid` cycle, given an uninterrupted release.
- Outputs are registered (FIFO head). `out_*` stay stable while `out_valid`&&!`out_ready`.
- `out_ready` is ignored when `out_valid`=0.

## Structure
- Package `morse_pkg`:
  - `morse_frame_t` (bits[5:0], len[2:0], err, space; 11 bits).
  - State enum.
  - Default gap thresholds.
- Sub-module `morse_frame_fifo`: 2-deep FWFT FIFO of `morse_frame_t`, with full/empty outputs and push/pop inputs.

## Test plan
Bench parameters: `CHAR_GAP_TH`=20, `WORD_GAP_TH`=50, `out_ready`=1 unless stated.
- Symbols dot, dash, then 25 idle cycles -> one frame: bits=6'b000010, len=2, err=0, space=0. `out_valid` high exactly 21 cycles after the last `sym_valid`.
- One dot, then 60 idle cycles -> letter frame (len=1, bits=0), then a space frame (len=0, space=1) 51 cycles after the `sym_valid`; state returns to IDLE.
- Seven dashes back to back -> bits=6'b111111, len=6, err=1.
- Symbol, then `btn_in` held high for 40 cycles, then another symbol -> single frame with len=2; no early close.
- `out_ready`=0; complete three characters -> two frames held stable, third dropped, `ovf`=1. Then `ovf_clr` -> `ovf`=0. Then `out_ready`=1 -> both stored frames drain in order.
- Assert `rst_n`=0 while in COLLECT with len=3 and the FIFO holding 1 entry -> `out_valid`=0 immediately (asynchronous), state IDLE, no frame emitted after release.
